// File: rtl/pc_conf_pkg.sv
// Shared types for the PC configuration mapper: op codes, input word layout
// and the chunks-per-word helper.
package pc_conf_pkg;

  localparam int CONF_NCONF = 16;
  localparam int CONF_IDXW  = 6;

  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_CHUNK = 2'd1,
    OP_READ  = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;

  typedef struct packed {
    op_e                   op;
    logic [CONF_IDXW-1:0]  idx;
    logic [CONF_NCONF-1:0] data;
  } conf_word_t;

  function automatic int chunks(input int nout, input int nconf);
    return (nout + nconf - 1) / nconf;
  endfunction

endpackage

// File: rtl/pc_conf_mapper_if.sv
// Handshake bundle of the config mapper: tagged input stream, per-channel
// deserializer outputs and the readback port.
interface pc_conf_mapper_if #(
  parameter int NCONF = 16,
  parameter int IDXW  = 6,
  parameter int NCHAN = 4,
  parameter int NOUT  = 51
);
  logic [2+IDXW+NCONF-1:0]    in_d;
  logic                       in_v;
  logic                       in_a;
  logic [NCHAN-1:0][NOUT-1:0] chan_d;
  logic [NCHAN-1:0]           chan_v;
  logic [NCHAN-1:0]           chan_a;
  logic [IDXW+NCONF-1:0]      rd_d;
  logic                       rd_v;
  logic                       rd_a;

  modport master (
    output in_d, in_v, chan_a, rd_a,
    input  in_a, chan_d, chan_v, rd_d, rd_v
  );

  modport slave (
    input  in_d, in_v, chan_a, rd_a,
    output in_a, chan_d, chan_v, rd_d, rd_v
  );
endinterface

// File: rtl/pc_conf_deser.sv
// One deserializer channel: collects CH chunks MS-first, then holds the word
// with valid asserted until acknowledged.
module pc_conf_deser
  import pc_conf_pkg::*;
#(
  parameter int NCONF = 16,
  parameter int NOUT  = 51
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCONF-1:0] chunk_i,
  input  logic             take_i,
  input  logic             ack_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [NOUT-1:0]  data_o
);
  localparam int CH = chunks(NOUT, NCONF);
  localparam int SW = CH * NCONF;
  localparam int CW = (CH > 1) ? $clog2(CH) : 1;

  localparam logic [0:0] ST_COLLECT = 1'b0;
  localparam logic [0:0] ST_FULL    = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] shreg_q, shreg_d;
  logic          last;

  assign last    = (cnt_q == CW'(CH - 1));
  assign ready_o = (state_q != ST_FULL) | ack_i;
  assign valid_o = (state_q == ST_FULL);
  assign data_o  = shreg_q[NOUT-1:0];

  // An ack and a new first chunk may land in the same cycle: release FULL
  // first, then let the accepted chunk advance the counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    if ((state_q == ST_FULL) && ack_i) state_d = ST_COLLECT;
    if (take_i) begin
      shreg_d = (shreg_q << NCONF) | SW'(chunk_i);
      if (last) begin
        cnt_d   = '0;
        state_d = ST_FULL;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_COLLECT;
      cnt_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
    end
  end

endmodule

// File: rtl/pc_conf_mapper.sv
// PC-side config mapper: register file with autoclear, NCHAN chunk
// deserializers, drop counter; readback enabled by CONF_READBACK_EN.
module pc_conf_mapper
  import pc_conf_pkg::*;
#(
  parameter int              NCONF        = CONF_NCONF,
  parameter int              NREG         = 32,
  parameter int              NCHAN        = 4,
  parameter int              NOUT         = 51,
  parameter int              IDXW         = CONF_IDXW,
  parameter logic [NREG-1:0] AUTOCLR_MASK = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NREG-1:0][NCONF-1:0] reg_reset_vals,
  pc_conf_mapper_if.slave            bus,
  output logic [NREG-1:0][NCONF-1:0] reg_out,
  output logic [NREG-1:0]            reg_wr,
  output logic [7:0]                 err_count
);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  op_e              op;
  logic [IDXW-1:0]  idx;
  logic [NCONF-1:0] data;
  logic             reg_ok, chan_ok;
  logic             in_a, xfer;
  logic             wr_hit, chunk_hit, rd_hit, drop;
  logic             chan_rdy_sel;
  logic [NCHAN-1:0] ch_ready, take;
  logic [NCONF-1:0] sel_val;

  logic [NREG-1:0][NCONF-1:0] reg_q, reg_d;
  logic [NREG-1:0]            reg_wr_q, reg_wr_d;
  logic [7:0]                 err_q, err_d;

  assign op      = op_e'(bus.in_d[IDXW+NCONF +: 2]);
  assign idx     = bus.in_d[NCONF +: IDXW];
  assign data    = bus.in_d[NCONF-1:0];
  assign reg_ok  = 32'(idx) < 32'(NREG);
  assign chan_ok = 32'(idx) < 32'(NCHAN);

`ifdef CONF_READBACK_EN
  logic                  rd_v_q, rd_v_d;
  logic [IDXW+NCONF-1:0] rd_d_q, rd_d_d;
`endif

  // Only an in-range CHUNK or READ can stall; everything else is taken at once.
  always_comb begin
    chan_rdy_sel = 1'b1;
    for (int c = 0; c < NCHAN; c++)
      if (32'(idx) == 32'(c)) chan_rdy_sel = ch_ready[c];
    in_a = 1'b1;
    case (op)
      OP_CHUNK: if (chan_ok) in_a = chan_rdy_sel;
`ifdef CONF_READBACK_EN
      OP_READ:  if (reg_ok) in_a = !rd_v_q | bus.rd_a;
`endif
      default:  in_a = 1'b1;
    endcase
  end

  assign bus.in_a  = in_a;
  assign xfer      = bus.in_v & in_a;
  assign wr_hit    = xfer && (op == OP_WRITE) && reg_ok;
  assign chunk_hit = xfer && (op == OP_CHUNK) && chan_ok;
`ifdef CONF_READBACK_EN
  assign rd_hit    = xfer && (op == OP_READ) && reg_ok;
`else
  assign rd_hit    = 1'b0;
`endif
  assign drop      = xfer && !(wr_hit || chunk_hit || rd_hit);

  always_comb begin
    take    = '0;
    sel_val = '0;
    for (int c = 0; c < NCHAN; c++)
      take[c] = chunk_hit && (32'(idx) == 32'(c));
    for (int r = 0; r < NREG; r++)
      if (32'(idx) == 32'(r)) sel_val = reg_q[r];
  end

  // A fresh write always beats the autoclear of the previous strobe.
  always_comb begin
    reg_d    = reg_q;
    reg_wr_d = '0;
    for (int r = 0; r < NREG; r++) begin
      if (wr_hit && (32'(idx) == 32'(r))) begin
        reg_d[r]    = data;
        reg_wr_d[r] = 1'b1;
      end else if (AUTOCLR_MASK[r] && reg_wr_q[r]) begin
        reg_d[r] = reg_reset_vals[r];
      end
    end
    err_d = drop ? sat_inc8(err_q) : err_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_q    <= reg_reset_vals;
      reg_wr_q <= '0;
      err_q    <= '0;
    end else begin
      reg_q    <= reg_d;
      reg_wr_q <= reg_wr_d;
      err_q    <= err_d;
    end
  end

  assign reg_out   = reg_q;
  assign reg_wr    = reg_wr_q;
  assign err_count = err_q;

`ifdef CONF_READBACK_EN
  always_comb begin
    rd_v_d = rd_v_q;
    rd_d_d = rd_d_q;
    if (rd_hit) begin
      rd_v_d = 1'b1;
      rd_d_d = {idx, sel_val};
    end else if (bus.rd_a) begin
      rd_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_v_q <= 1'b0;
      rd_d_q <= '0;
    end else begin
      rd_v_q <= rd_v_d;
      rd_d_q <= rd_d_d;
    end
  end

  assign bus.rd_v = rd_v_q;
  assign bus.rd_d = rd_d_q;
`else
  logic                  unused_rd_a;
  logic [NCONF-1:0]      unused_sel_val;
  assign unused_rd_a    = bus.rd_a;
  assign unused_sel_val = sel_val;
  assign bus.rd_v       = 1'b0;
  assign bus.rd_d       = '0;
`endif

  for (genvar c = 0; c < NCHAN; c++) begin : g_ch
    pc_conf_deser #(
      .NCONF (NCONF),
      .NOUT  (NOUT)
    ) u_deser (
      .clk     (clk),
      .reset   (reset),
      .chunk_i (data),
      .take_i  (take[c]),
      .ack_i   (bus.chan_a[c]),
      .ready_o (ch_ready[c]),
      .valid_o (bus.chan_v[c]),
      .data_o  (bus.chan_d[c])
    );
  end

endmodule

// File: doc/pc_conf_mapper.md
Name: pc_conf_mapper

Overview:
Next-generation PC-side configuration mapper. It consumes one tagged config-word stream and does three things:
- Writes an Nreg x Nconf register file with per-register reset values and optional self-clearing strobe registers.
- Steers data chunks to NCHAN independent deserializers with per-channel valid/ack outputs.
- Optionally answers register readback requests.

It sits between the PC packet parser and the SpikeFilter, SpikeGenerator, TimeMgr, TagSplit and BDIO config consumers.

Parameters:
- NCONF, 16, data bits per config word.
- NREG, 32, number of config registers.
- NCHAN, 4, number of deserializer channels.
- NOUT, 51, deserialized word width per channel.
- IDXW, 6, index field width; must be at least clog2(max(NREG,NCHAN)).
- AUTOCLR_MASK, NREG'b0, bit r=1 makes register r self-clearing.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- reg_reset_vals  in  NREG x NCONF  per-register reset/clear values.
- in_d  in  2+IDXW+NCONF  {op[1:0], idx, data}.
- in_v  in  1  input valid.
- in_a  out  1  input ack.
- reg_out  out  NREG x NCONF  register file contents.
- reg_wr  out  NREG  one-cycle write strobe per register.
- chan_d  out  NCHAN x NOUT  deserialized words.
- chan_v  out  NCHAN  channel valid.
- chan_a  in  NCHAN  channel ack.
- rd_d  out  IDXW+NCONF  readback {idx, value}.
- rd_v  out  1  readback valid.
- rd_a  in  1  readback ack.
- err_count  out  8  dropped-word counter, saturating.

Behaviour:
- Reset (reset=0, asynchronous) drives outputs as follows:
  - reg_out = reg_reset_vals.
  - reg_wr = 0, chan_v = 0, chan_d = 0.
  - rd_v = 0, rd_d = 0.
  - err_count = 0.
  - All deserializer chunk counters = 0; partial words are discarded.
  - Deassertion mid-stream restarts cleanly and never emits a stale partial word.
- Transfer happens at the clk edge where in_v & in_a. in_a is combinational from in_v, op, idx and downstream state. At most one word is consumed per cycle.
- op 0, WRITE:
  - Always accepted.
  - reg_out[idx] = data and reg_wr[idx] = 1 on the following cycle (latency 1).
  - If AUTOCLR_MASK[idx] = 1, reg_out[idx] returns to reg_reset_vals[idx] one cycle later unless rewritten that cycle. Back-to-back writes give one strobe per write, and the last write wins.
- op 1, CHUNK, goes to deserializer idx:
  - Chunks are ordered most-significant first. CH = ceil(NOUT/NCONF). The output is the low NOUT bits of the CH concatenated chunks.
  - Deserializer states: COLLECT(k), k = 0..CH-1, then FULL.
  - Accepting the chunk at k = CH-1 moves to FULL, with chan_v=1 the next cycle.
  - In FULL: chan_d is stable and chan_v is held until chan_a; then the deserializer returns to COLLECT(0).
  - in_a for a chunk = !FULL | chan_a[idx]. A same-cycle ack-and-accept is legal and starts the next word at k=1.
  - A stalled chunk blocks the whole input stream (head-of-line). Other channels' outputs continue to drain.
- op 2, READ (CONF_READBACK_EN only):
  - Accepted when !rd_v | rd_a.
  - Next cycle: rd_v=1, rd_d = {idx, reg_out[idx] as seen in the accept cycle}. rd_v is held until rd_a.
- Drops (consumed with in_a=1, no other effect, err_count += 1, saturating at 255):
  - WRITE or READ with idx >= NREG.
  - CHUNK with idx >= NCHAN.
  - op 3.
  - op 2 when readback is compiled out.

Optional Feature:
- CONF_READBACK_EN defined: READ op, rd_d, rd_v and rd_a are active as described above.
- CONF_READBACK_EN undefined:
  - rd_v tied 0, rd_d tied 0, rd_a ignored.
  - op 2 is dropped as an error.

Decomposition:
- Package pc_conf_pkg holds:
  - op enum (WRITE, CHUNK, READ, RSVD).
  - in-word packed struct.
  - function chunks(nout, nconf) returning the ceiling division.
- Sub-module pc_conf_deser: one per channel, generated NCHAN times. It contains the chunk counter, shift register and FULL/valid handshake.
- Top level holds the decode, in_a mux, register file, autoclear logic, readback register and error counter.

Test Plan:
- Reset with reg_reset_vals[5]=100, then release -> reg_out[5]=100, all valids 0, err_count=0.
- WRITE idx=3 data=0xBEEF -> next cycle reg_out[3]=0xBEEF and reg_wr=1<<3 for exactly 1 cycle.
- AUTOCLR_MASK bit 7 set; WRITE idx=7 data=1 -> reg_out[7]=1 for one cycle, then returns to reset value 0.
- 4 CHUNKs to channel 2 (0x0007, 0x1234, 0x5678, 0x9ABC), chan_a[2] held 0 for 5 cycles:
  - chan_d[2]=51'h7_1234_5678_9ABC and chan_v[2]=1 one cycle after the last chunk.
  - A fifth chunk to channel 2 sees in_a=0 until chan_a[2]=1, then is accepted that same cycle.
- CHUNK idx=9 (NCHAN=4), WRITE idx=40, op 3 -> each acked, err_count=3; 300 bad words -> err_count=255.
- CONF_READBACK_EN: WRITE idx=1 data=0x00A5, then READ idx=1 with rd_a=0:
  - rd_v=1, rd_d={1, 0x00A5}.
  - A second READ is stalled until rd_a=1.
